// File: rtl/attn_out_streamer.sv
// Streams a captured attention result frame (L rows x E elements) as ready/valid beats.
// Optional ATTN_STREAM_ROW_SUM_EN adds one saturated row-sum beat after each row.
module attn_out_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 16,
  parameter int E          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_done,
  input  logic [DATA_WIDTH-1:0] src_out [L*E],
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_row_last,
  output logic                  m_frame_last,
  output logic                  m_is_sum,
  output logic                  busy,
  output logic                  overrun
);

  localparam int N  = L * E;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = (E > 1) ? $clog2(E) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(L - 1);
  localparam logic [CW-1:0] C_LAST = CW'(E - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
`ifdef ATTN_STREAM_ROW_SUM_EN
  localparam logic [1:0] S_SUM    = 2'd2;
  localparam int ACC_W = DATA_WIDTH + $clog2(E);
`endif

  // Handshake: a beat moves on a rising edge where m_valid=1 and m_ready=1;
  // while m_valid=1 and m_ready=0 every payload/flag output holds, and
  // m_valid is never a function of m_ready in the same cycle.

  logic [1:0]            state, state_n;
  logic [RW-1:0]         r, r_n;
  logic [CW-1:0]         c, c_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  valid_n, row_last_n, frame_last_n, busy_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  load_elem;
  logic [DATA_WIDTH-1:0] buffer [N];

  logic xfer, capture;
  assign xfer    = m_valid & m_ready;
  // A new frame may be taken when idle or exactly as the final beat leaves.
  assign capture = src_done & ((state == S_IDLE) | (xfer & m_frame_last));

`ifdef ATTN_STREAM_ROW_SUM_EN
  logic signed [ACC_W-1:0]           acc, acc_n, elem_ext, acc_sum;
  logic [ACC_W-DATA_WIDTH:0]         acc_top;
  logic [DATA_WIDTH-1:0]             sum_sat;
  logic                              is_sum, is_sum_n;

  assign elem_ext = ACC_W'($signed(m_data));
  assign acc_sum  = acc + elem_ext;
  assign acc_top  = acc_sum[ACC_W-1:DATA_WIDTH-1];
  assign sum_sat  = ((&acc_top) || ~(|acc_top)) ? acc_sum[DATA_WIDTH-1:0] :
                    acc_sum[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                       {1'b0, {(DATA_WIDTH-1){1'b1}}};
  assign m_is_sum = is_sum;
`else
  assign m_is_sum = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    r_n          = r;
    c_n          = c;
    idx_n        = idx;
    valid_n      = m_valid;
    data_n       = m_data;
    row_last_n   = m_row_last;
    frame_last_n = m_frame_last;
    load_elem    = 1'b0;
`ifdef ATTN_STREAM_ROW_SUM_EN
    is_sum_n     = is_sum;
    acc_n        = acc;
`endif
    if (capture) begin
      state_n   = S_STREAM;
      r_n       = '0;
      c_n       = '0;
      idx_n     = '0;
      load_elem = 1'b1;
`ifdef ATTN_STREAM_ROW_SUM_EN
      acc_n     = '0;
`endif
    end else if (xfer) begin
      if (m_frame_last) begin
        state_n      = S_IDLE;
        r_n          = '0;
        c_n          = '0;
        idx_n        = '0;
        valid_n      = 1'b0;
        data_n       = '0;
        row_last_n   = 1'b0;
        frame_last_n = 1'b0;
`ifdef ATTN_STREAM_ROW_SUM_EN
        is_sum_n     = 1'b0;
      end else if (state == S_SUM) begin
        state_n   = S_STREAM;
        r_n       = r + 1'b1;
        c_n       = '0;
        idx_n     = idx + 1'b1;
        load_elem = 1'b1;
      end else if (c == C_LAST) begin
        state_n      = S_SUM;
        data_n       = sum_sat;
        row_last_n   = 1'b1;
        frame_last_n = (r == R_LAST);
        is_sum_n     = 1'b1;
        acc_n        = '0;
`endif
      end else begin
        if (c == C_LAST) begin
          c_n = '0;
          r_n = r + 1'b1;
        end else begin
          c_n = c + 1'b1;
        end
        idx_n     = idx + 1'b1;
        load_elem = 1'b1;
`ifdef ATTN_STREAM_ROW_SUM_EN
        acc_n     = acc_sum;
`endif
      end
    end

    if (load_elem) begin
      valid_n = 1'b1;
      data_n  = capture ? src_out[0] : buffer[idx_n];
`ifdef ATTN_STREAM_ROW_SUM_EN
      // Row/frame markers belong to the sum beat in this build.
      row_last_n   = 1'b0;
      frame_last_n = 1'b0;
      is_sum_n     = 1'b0;
`else
      row_last_n   = (c_n == C_LAST);
      frame_last_n = (c_n == C_LAST) && (r_n == R_LAST);
`endif
    end
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (capture) buffer <= src_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      r            <= '0;
      c            <= '0;
      idx          <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_row_last   <= 1'b0;
      m_frame_last <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
`ifdef ATTN_STREAM_ROW_SUM_EN
      is_sum       <= 1'b0;
      acc          <= '0;
`endif
    end else begin
      state        <= state_n;
      r            <= r_n;
      c            <= c_n;
      idx          <= idx_n;
      m_valid      <= valid_n;
      m_data       <= data_n;
      m_row_last   <= row_last_n;
      m_frame_last <= frame_last_n;
      busy         <= busy_n;
      overrun      <= overrun | (src_done & ~capture);
`ifdef ATTN_STREAM_ROW_SUM_EN
      is_sum       <= is_sum_n;
      acc          <= acc_n;
`endif
    end
  end

endmodule

// File: tb/tb_attn_out_streamer.sv
// Scoreboard bench for attn_out_streamer at L=E=4: directed frames, overrun,
// back-to-back, mid-frame reset, backpressure and (with ATTN_STREAM_ROW_SUM_EN) row sums.
module tb_attn_out_streamer;
  localparam int DW = 16;
  localparam int L  = 4;
  localparam int E  = 4;
  localparam int N  = L * E;
`ifdef ATTN_STREAM_ROW_SUM_EN
  localparam int BEATS = L * (E + 1);
`else
  localparam int BEATS = L * E;
`endif

  logic          clk;
  logic          rst_n;
  logic          src_done;
  logic [DW-1:0] src_out [N];
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_row_last;
  logic          m_frame_last;
  logic          m_is_sum;
  logic          busy;
  logic          overrun;

  attn_out_streamer #(.DATA_WIDTH(DW), .L(L), .E(E)) dut (
    .clk(clk), .rst_n(rst_n), .src_done(src_done), .src_out(src_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row_last(m_row_last), .m_frame_last(m_frame_last), .m_is_sum(m_is_sum),
    .busy(busy), .overrun(overrun)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int beats_seen = 0;
  logic [DW+2:0] exp_q[$];
  logic [DW-1:0] f [N];

  logic [DW+2:0] cur;
  assign cur = {m_data, m_row_last, m_frame_last, m_is_sum};

  // Monitor: stall stability and in-order beat comparison
  logic          stall_prev = 1'b0;
  logic [DW+2:0] held = '0;
  logic [DW+2:0] exp_beat;
  always @(negedge clk) begin
    if (rst_n && stall_prev) begin
      checks++;
      if (!m_valid || cur !== held) begin
        failures++;
        $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h", m_valid, cur, held);
      end
    end
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got beat=%h, required no beat", cur);
      end else begin
        exp_beat = exp_q.pop_front();
        if (cur !== exp_beat) begin
          failures++;
          $display("FAIL beat: got {data,row_last,frame_last,is_sum}=%h, required %h", cur, exp_beat);
        end
      end
      beats_seen++;
    end
    stall_prev = rst_n && m_valid && !m_ready;
    held       = cur;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},      32'(m_valid),      32'd0);
    check({tag, "_data"},       32'(m_data),       32'd0);
    check({tag, "_row_last"},   32'(m_row_last),   32'd0);
    check({tag, "_frame_last"}, 32'(m_frame_last), 32'd0);
    check({tag, "_is_sum"},     32'(m_is_sum),     32'd0);
    check({tag, "_busy"},       32'(busy),         32'd0);
    check({tag, "_overrun"},    32'(overrun),      32'd0);
  endtask

  // Expected-beat model for a frame; only the first 'count' beats are queued.
  task automatic push_frame(input logic [DW-1:0] fr [N], input int count);
    logic [DW+2:0] list[$];
    int sum;
    int idx;
    logic [DW-1:0] sat;
    for (int r = 0; r < L; r++) begin
      sum = 0;
      for (int c = 0; c < E; c++) begin
        idx = r * E + c;
        sum += int'($signed(fr[idx]));
`ifdef ATTN_STREAM_ROW_SUM_EN
        list.push_back({fr[idx], 1'b0, 1'b0, 1'b0});
`else
        list.push_back({fr[idx], (c == E-1), (c == E-1 && r == L-1), 1'b0});
`endif
      end
`ifdef ATTN_STREAM_ROW_SUM_EN
      if (sum > 32767) sat = 16'h7FFF;
      else if (sum < -32768) sat = 16'h8000;
      else sat = DW'(sum);
      list.push_back({sat, 1'b1, (r == L-1), 1'b1});
`endif
    end
    for (int i = 0; i < count; i++) exp_q.push_back(list[i]);
  endtask

  task automatic fill(input int base, input int step);
    for (int i = 0; i < N; i++) f[i] = DW'(base + i * step);
    src_out = f;
  endtask

  // Returns 1ns into the first beat cycle (just after the capture edge).
  task automatic capture_pulse();
    @(posedge clk); #1 src_done = 1'b1;
    @(posedge clk); #1 src_done = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_valid_low"}, 32'(m_valid), 32'd0);
    check({tag, "_busy_low"},  32'(busy),    32'd0);
    check({tag, "_drained"},   32'(exp_q.size()), 32'd0);
  endtask

  int k;
  int start_beats;
  logic [DW-1:0] sums [L];

  initial begin
    rst_n = 1'b0;
    src_done = 1'b0;
    m_ready = 1'b1;
    fill(0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic frame: data 0..15, one beat per cycle from the cycle after src_done
    fill(0, 1);
    push_frame(f, BEATS);
    capture_pulse();
    @(negedge clk);
    check("basic_latency_valid", 32'(m_valid), 32'd1);
    check("basic_first_data",    32'(m_data),  32'd0);
    check("basic_busy",          32'(busy),    32'd1);
    repeat (BEATS) @(posedge clk);
    expect_idle("basic");
    check("basic_no_overrun", 32'(overrun), 32'd0);

    // Overrun: second pulse during beat 5 is ignored
    fill(50, 1);
    push_frame(f, BEATS);
    capture_pulse();
    repeat (5) @(posedge clk);
    #1;
    fill(16'hDEAD, 0);
    src_done = 1'b1;
    @(posedge clk); #1 src_done = 1'b0;
    @(negedge clk);
    check("overrun_set",       32'(overrun), 32'd1);
    check("overrun_streaming", 32'(m_valid), 32'd1);
    repeat (BEATS - 6) @(posedge clk);
    expect_idle("overrun");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Back-to-back: new src_done coincides with final-beat transfer
    do_reset();
    fill(200, 1);
    push_frame(f, BEATS);
    capture_pulse();
    repeat (BEATS - 1) @(posedge clk);
    #1;
    fill(300, 1);
    push_frame(f, BEATS);
    src_done = 1'b1;
    @(posedge clk); #1 src_done = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", 32'(m_valid), 32'd1);
    check("b2b_first_data", 32'(m_data), 32'd300);
    check("b2b_no_overrun", 32'(overrun), 32'd0);
    repeat (BEATS) @(posedge clk);
    expect_idle("b2b");

    // Mid-frame reset at beat 6: only beats 0..5 transfer
    fill(400, 1);
    push_frame(f, 6);
    capture_pulse();
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    expect_idle("midreset");

    // First src_done after reset release is captured normally
    fill(0, 3);
    push_frame(f, BEATS);
    capture_pulse();
    repeat (BEATS) @(posedge clk);
    expect_idle("post_reset");

    // Backpressure: m_ready pattern 1,0,0,1
    fill(0, 1);
    push_frame(f, BEATS);
    start_beats = beats_seen;
    capture_pulse();
    k = 0;
    while (exp_q.size() > 0 && k < 400) begin
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(posedge clk); #1;
      k++;
    end
    m_ready = 1'b1;
    check("bp_beat_count", 32'(beats_seen - start_beats), 32'(BEATS));
    expect_idle("bp");

`ifdef ATTN_STREAM_ROW_SUM_EN
    // Row sums: 6000h x4 saturates, {1,2,3,4}=10, {-1,-2,3,5}=5, 8000h x4 saturates low
    for (int i = 0; i < 4; i++) begin
      f[i]      = 16'h6000;
      f[4 + i]  = DW'(i + 1);
      f[12 + i] = 16'h8000;
    end
    f[8] = 16'hFFFF; f[9] = 16'hFFFE; f[10] = 16'h0003; f[11] = 16'h0005;
    src_out = f;
    sums[0] = 16'h7FFF; sums[1] = 16'h000A; sums[2] = 16'h0005; sums[3] = 16'h8000;
    for (int r = 0; r < L; r++) begin
      for (int c = 0; c < E; c++) exp_q.push_back({f[r*E + c], 1'b0, 1'b0, 1'b0});
      exp_q.push_back({sums[r], 1'b1, (r == L-1), 1'b1});
    end
    start_beats = beats_seen;
    capture_pulse();
    repeat (20) @(posedge clk);
    expect_idle("sum");
    check("sum_frame_len", 32'(beats_seen - start_beats), 32'd20);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/attn_out_streamer.md
ATTN_OUT_STREAMER -- requirements
Module: attn_out_streamer

Interface
- REQ-001 The parameters SHALL be, one per line: name, default, meaning.
  - DATA_WIDTH, 16, element width (Q1.15).
  - L, 16, tokens (rows) per frame.
  - E, 16, elements per row.
- REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
  - clk, input, 1, single clock; all logic on its rising edge.
  - rst_n, input, 1, reset; asynchronous, active-low.
  - src_done, input, 1, one-cycle frame-complete pulse from the attention top.
  - src_out, input, DATA_WIDTH x L*E unpacked array, row-major result frame, valid in the src_done cycle.
  - m_valid, output, 1, stream beat valid.
  - m_ready, input, 1, downstream accept.
  - m_data, output, DATA_WIDTH, beat payload.
  - m_row_last, output, 1, final beat of a row.
  - m_frame_last, output, 1, final beat of the frame.
  - m_is_sum, output, 1, beat carries a row sum.
  - busy, output, 1, frame held or streaming.
  - overrun, output, 1, sticky: a frame was dropped.

Function
- REQ-003 States SHALL be S_IDLE, S_STREAM and S_SUM.
- REQ-004 In S_IDLE with src_done=1, the block SHALL capture all L*E src_out words into an internal buffer, zero its row counter r and column counter c, and enter S_STREAM.
- REQ-005 m_valid SHALL assert the cycle after capture, giving 1-cycle latency from src_done.
- REQ-006 In S_STREAM, m_data SHALL equal buffer[r*E+c].
- REQ-007 A beat SHALL transfer only in a cycle with m_valid=1 and m_ready=1.
- REQ-008 While m_valid=1 and m_ready=0, m_data, m_row_last, m_frame_last and m_is_sum SHALL hold stable.
- REQ-009 On each transfer, c SHALL increment; at c=E-1 it SHALL wrap to 0 and r SHALL increment.
- REQ-010 m_row_last SHALL be 1 on the c=E-1 beat.
- REQ-011 m_frame_last SHALL be 1 on the r=L-1, c=E-1 beat.
- REQ-012 After the final beat transfers, the block SHALL enter S_IDLE, and m_valid SHALL deassert the next cycle unless REQ-013 applies.
- REQ-013 If src_done=1 in the same cycle as the final-beat transfer, the block SHALL capture the new frame and continue streaming with no bubble cycle.
- REQ-014 If src_done=1 in any other non-idle cycle, the block SHALL ignore the pulse, leave the buffer unchanged, and set overrun=1.
- REQ-015 overrun SHALL stay at 1 until reset.
- REQ-016 busy SHALL be 1 in every state except S_IDLE.
- REQ-017 m_is_sum SHALL be 0 on every S_STREAM beat.
- REQ-018 m_valid SHALL never depend combinationally on m_ready.
- REQ-019 All outputs SHALL be registered.

Reset
- REQ-020 While rst_n=0, the block SHALL set state=S_IDLE, r=c=0, m_valid=0, m_data=0, m_row_last=0, m_frame_last=0, m_is_sum=0, busy=0 and overrun=0.
- REQ-021 The buffer contents need not be cleared by reset.
- REQ-022 A reset asserted mid-frame SHALL abandon the frame; after release, no beats of that frame SHALL be emitted.
- REQ-023 The first src_done after reset release SHALL be captured normally.

Configuration
- REQ-024 The macro ATTN_STREAM_ROW_SUM_EN SHALL be the only compile-time option.
- REQ-025 With ATTN_STREAM_ROW_SUM_EN defined, the block SHALL accumulate each row in a signed register of DATA_WIDTH+$clog2(E) bits as beats are captured or sent.
- REQ-026 With ATTN_STREAM_ROW_SUM_EN defined, after the c=E-1 element beat the block SHALL enter S_SUM and emit one extra beat with m_is_sum=1 and m_data=the row sum saturated to 16'h7FFF or 16'h8000.
- REQ-027 With ATTN_STREAM_ROW_SUM_EN defined, m_row_last SHALL move from the c=E-1 element beat to the sum beat, and m_frame_last SHALL move to the row L-1 sum beat.
- REQ-028 With ATTN_STREAM_ROW_SUM_EN defined, a frame SHALL contain L*(E+1) beats.
- REQ-029 With ATTN_STREAM_ROW_SUM_EN undefined, S_SUM and the accumulator SHALL not exist, m_is_sum SHALL be tied to 0, and a frame SHALL contain L*E beats.

Verification
- REQ-030 The bench SHALL cover these scenarios with L=E=4 and m_ready held at 1:
  - Basic frame: src_out[i]=i, one src_done pulse -> 16 beats carrying data 0..15 on consecutive cycles, starting the cycle after src_done; m_row_last on beats 3, 7, 11 and 15; m_frame_last on beat 15 only.
  - Overrun: a second src_done pulse at beat 5 -> the stream continues with the original data, overrun=1, and overrun is still 1 after the frame ends.
  - Back-to-back frames: a second src_done coincides with the beat-15 transfer -> frame 2's beat 0 appears on the next cycle with no bubble and overrun=0.
  - Mid-frame reset: rst_n pulsed low for 1 cycle at beat 6 -> all outputs read 0 and no further beats are emitted until a new src_done.
- REQ-031 The bench SHALL cover backpressure: m_ready toggled 1,0,0,1 repeatedly -> m_data is stable during every stall and the full 0..15 sequence arrives with no loss or duplication.
- REQ-032 The bench SHALL cover the sum beat with ATTN_STREAM_ROW_SUM_EN defined: row 0 = 16'h6000 x4 -> sum beat 16'h7FFF, m_is_sum=1 and m_row_last=1; row 1 = {1,2,3,4} -> sum beat 16'h000A; the frame is 20 beats long.
